quad_gen: RTL and testbench
===========================

QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 Parameter DIVW, default 16: width of the dwell input and the dwell counter.
REQ-002 Parameter BOUNCE_CYCLES, default 0: chatter cycles injected after each transition; 0 disables chatter.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted on a clk edge where cmd_valid && cmd_ready.
REQ-007 cmd_dir  input  1  1 = forward, 0 = reverse; sampled at acceptance.
REQ-008 cmd_steps  input  8  number of quadrature transitions; sampled at acceptance.
REQ-009 dwell  input  DIVW  settled cycles per phase; sampled at acceptance; 0 is treated as 1.
REQ-010 cmd_abort  input  1  synchronous abort of the running command.
REQ-011 a  output  1  quadrature channel A, registered.
REQ-012 b  output  1  quadrature channel B, registered.
REQ-013 busy  output  1  high while a command executes.
REQ-014 done  output  1  one-cycle pulse when a command completes normally.
REQ-015 position  output  16  signed count of settled transitions emitted.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BOUNCE and DWELL.
REQ-017 cmd_ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-018 Forward SHALL step the settled (a,b) phase 00->10->11->01->00; reverse SHALL step 00->01->11->10->00.
REQ-019 Exactly one of a or b SHALL change per step.
REQ-020 Phase SHALL persist across commands and SHALL NOT reset to 00 per command.
REQ-021 On acceptance with cmd_steps != 0, the first transition SHALL be visible on a/b in the cycle after the accepting edge.
REQ-022 On that transition, position SHALL change by +1 (forward) or -1 (reverse), with two's-complement wrap (32767+1 -> -32768).
REQ-023 With BOUNCE_CYCLES > 0, the changed line SHALL show the old value on the 2nd, 4th, ... chatter cycles and the new value otherwise, for BOUNCE_CYCLES cycles after each transition; state = BOUNCE.
REQ-024 After chatter, the new settled value SHALL hold for the effective dwell (max(dwell,1)) cycles; state = DWELL.
REQ-025 When the dwell expires and steps remain, the next transition SHALL occur on the following edge.
REQ-026 Each step SHALL therefore occupy BOUNCE_CYCLES + max(dwell,1) cycles.
REQ-027 After the last step's dwell, done SHALL pulse for one cycle coincident with the return to IDLE; cmd_ready SHALL be high in that same cycle.
REQ-028 On acceptance with cmd_steps == 0, the block SHALL stay in IDLE, leave a/b/position unchanged, and pulse done in the next cycle.
REQ-029 cmd_abort in BOUNCE or DWELL SHALL return the FSM to IDLE on the next edge.
REQ-030 On abort, a/b SHALL be forced to the current settled phase (chatter cancelled), position SHALL be retained, and done SHALL NOT pulse.
REQ-031 cmd_abort in IDLE SHALL be ignored, and abort SHALL have priority over acceptance in the same cycle.
REQ-032 cmd_valid while busy SHALL be ignored; the held command is not queued.
REQ-033 cmd_dir, cmd_steps and dwell changing during execution SHALL have no effect.

Reset
REQ-034 While reset is low, the block SHALL hold: a=0, b=0, phase=00, position=0, done=0, state=IDLE (cmd_ready=1, busy=0), all counters 0.
REQ-035 Assertion SHALL take effect asynchronously, including mid-command; no done pulse SHALL follow.
REQ-036 Release SHALL be synchronous to clk; the first acceptance is possible on the first edge after release.

Verification
REQ-037 BOUNCE_CYCLES=0, after reset, forward, steps=4, dwell=3 -> (a,b) = 10,11,01,00, each held 3 cycles; done pulses at cycle 12 after accept; position=4.
REQ-038 Then reverse, steps=5, dwell=0 -> (a,b) = 01,11,10,00,01, one cycle each; position=-1; done at cycle 5.
REQ-039 BOUNCE_CYCLES=4, forward, steps=1, dwell=2 from phase 00 -> a = 1,0,1,0 then 1,1; b=0 throughout; done at cycle 6.
REQ-040 Abort asserted mid-command during chatter -> IDLE next edge; a/b at settled phase; no done; new command accepted the following cycle.
REQ-041 Wrap and zero-step: position preloaded to 32767 via 32767 forward steps (dwell=1), then forward steps=1 -> position=-32768; then steps=0 -> done next cycle, a/b unchanged.
REQ-042 Reset pulled low at step 2 of a 10-step command -> a=b=0, position=0, busy=0 immediately (asynchronously); no done after release.

Source files
------------

// File: rtl/quad_gen.sv
// -----------------------------------------------------------------------------
// quad_gen -- quadrature (A/B) step generator with optional contact chatter.
//
// A command (direction, step count, dwell) is accepted through a valid/ready
// handshake. The generator then emits cmd_steps Gray-code transitions on a/b.
// After each transition, the changed line can chatter for BOUNCE_CYCLES cycles.
// The new value then holds for max(dwell,1) settled cycles. position tracks
// the signed count of transitions emitted (forward +1, reverse -1) and wraps.
// The settled phase carries over from one command to the next.
//
// Parameters
//   DIVW          width of dwell and of the dwell counter
//   BOUNCE_CYCLES chatter cycles after each transition (0 = no chatter)
//
// Ports
//   clk        clock
//   reset      asynchronous active-low reset
//   cmd_valid  command offered          cmd_ready  FSM idle, command accepted
//   cmd_dir    1 = forward, 0 = reverse cmd_steps  transitions to emit
//   dwell      settled cycles per phase (0 treated as 1)
//   cmd_abort  cancel the running command (no done pulse)
//   a, b       registered quadrature outputs
//   busy       command executing        done       one-cycle completion pulse
//   position   signed transition count
// -----------------------------------------------------------------------------
module quad_gen #(
  parameter int DIVW          = 16,
  parameter int BOUNCE_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [7:0]         cmd_steps,
  input  logic [DIVW-1:0]    dwell,
  input  logic               cmd_abort,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] position
);

  typedef enum logic [1:0] {IDLE, BOUNCE, DWELL} state_t;

  // Width of the chatter-cycle index. It is kept at least 1 bit so that the
  // no-chatter build still elaborates.
  localparam int            BW          = (BOUNCE_CYCLES < 2) ? 1 : $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BW-1:0] BOUNCE_LAST = BW'(BOUNCE_CYCLES);

  // Next settled phase {a,b}. Forward: 00->10->11->01. Reverse: 00->01->11->10.
  function automatic logic [1:0] step_phase(input logic [1:0] p, input logic fwd);
    return fwd ? {~p[0], p[1]} : {p[0], ~p[1]};
  endfunction

  state_t               state, state_n;
  logic [1:0]           phase, phase_n;       // settled phase
  logic [1:0]           prev_phase, prev_n;   // phase before the last transition
  logic [1:0]           ab, ab_n;             // registered line values
  logic signed [15:0]   pos_q, pos_n;
  logic                 dir_q, dir_n;
  logic [7:0]           steps_left, steps_n;  // transitions still to emit after the current one
  logic [DIVW-1:0]      dwell_q, dwell_n;     // effective dwell, never 0
  logic [BW-1:0]        bcnt, bcnt_n;         // index of the chatter cycle on the lines, 1-based
  logic [DIVW-1:0]      dcnt, dcnt_n;         // index of the dwell cycle on the lines, 1-based
  logic                 done_q, done_n;
  logic                 launch, launch_dir;

  always_comb begin
    // NOTE: every variable gets a default before the case statement. Without
    // a default, a path that does not assign it would infer a latch.
    state_n    = state;
    phase_n    = phase;
    prev_n     = prev_phase;
    ab_n       = ab;
    pos_n      = pos_q;
    dir_n      = dir_q;
    steps_n    = steps_left;
    dwell_n    = dwell_q;
    bcnt_n     = bcnt;
    dcnt_n     = dcnt;
    done_n     = 1'b0;
    launch     = 1'b0;
    launch_dir = dir_q;

    case (state)
      IDLE: begin
        // Abort has priority, so a command offered together with abort is not taken.
        if (cmd_valid && !cmd_abort) begin
          dir_n   = cmd_dir;
          dwell_n = (dwell == '0) ? DIVW'(1) : dwell;
          if (cmd_steps == 8'd0) begin
            done_n = 1'b1;
          end else begin
            steps_n    = cmd_steps - 8'd1;
            launch     = 1'b1;
            launch_dir = cmd_dir;
          end
        end
      end

      BOUNCE: begin
        if (cmd_abort) begin
          state_n = IDLE;
          ab_n    = phase;
          bcnt_n  = '0;
          steps_n = '0;
        end else if (bcnt == BOUNCE_LAST) begin
          state_n = DWELL;
          ab_n    = phase;
          bcnt_n  = '0;
          dcnt_n  = DIVW'(1);
        end else begin
          // Only one line differs between prev_phase and phase. Showing
          // prev_phase on the even chatter cycles therefore bounces just that line.
          bcnt_n = bcnt + BW'(1);
          ab_n   = bcnt[0] ? prev_phase : phase;
        end
      end

      DWELL: begin
        if (cmd_abort) begin
          state_n = IDLE;
          ab_n    = phase;
          dcnt_n  = '0;
          steps_n = '0;
        end else if (dcnt == dwell_q) begin
          if (steps_left == 8'd0) begin
            state_n = IDLE;
            done_n  = 1'b1;
            dcnt_n  = '0;
          end else begin
            steps_n = steps_left - 8'd1;
            launch  = 1'b1;
          end
        end else begin
          dcnt_n = dcnt + DIVW'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // A transition from IDLE uses the same logic as one chained from an expiring dwell.
    if (launch) begin
      prev_n  = phase;
      phase_n = step_phase(phase, launch_dir);
      ab_n    = phase_n;
      pos_n   = launch_dir ? pos_q + 16'sd1 : pos_q - 16'sd1;
      if (BOUNCE_CYCLES > 0) begin
        state_n = BOUNCE;
        bcnt_n  = BW'(1);
        dcnt_n  = '0;
      end else begin
        state_n = DWELL;
        dcnt_n  = DIVW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= 2'b00;
      prev_phase <= 2'b00;
      ab         <= 2'b00;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      steps_left <= '0;
      dwell_q    <= '0;
      bcnt       <= '0;
      dcnt       <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      prev_phase <= prev_n;
      ab         <= ab_n;
      pos_q      <= pos_n;
      dir_q      <= dir_n;
      steps_left <= steps_n;
      dwell_q    <= dwell_n;
      bcnt       <= bcnt_n;
      dcnt       <= dcnt_n;
      done_q     <= done_n;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign a         = ab[1];
  assign b         = ab[0];
  assign done      = done_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_gen -- directed checks of quad_gen. Two instances are used:
// dut0 without chatter and dut4 with BOUNCE_CYCLES = 4.
// Both instances share the clock, the reset and the command fields. Each has
// its own cmd_valid.
// -----------------------------------------------------------------------------
module tb_quad_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v4;
  logic        dir;
  logic [7:0]  steps;
  logic [15:0] dwell;
  logic        abort;

  logic        rdy0, a0, b0, busy0, done0;
  logic [15:0] pos0;
  logic        rdy4, a4, b4, busy4, done4;
  logic [15:0] pos4;

  int n_tests = 0;
  int n_fail  = 0;

  quad_gen #(.DIVW(16), .BOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_dir(dir),
    .cmd_steps(steps), .dwell(dwell), .cmd_abort(abort), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .position(pos0)
  );

  quad_gen #(.DIVW(16), .BOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_dir(dir),
    .cmd_steps(steps), .dwell(dwell), .cmd_abort(abort), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .position(pos4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one command on dut0 and wait, within a bounded number of cycles, for done.
  task automatic run_cmd0(input logic d, input logic [7:0] s, input logic [15:0] w, input int bound);
    bit seen;
    dir = d; steps = s; dwell = w; v0 = 1'b1;
    step();
    v0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (done0) seen = 1'b1;
    end
    check("cmd_done_seen", 32'(seen), 32'd1);
  endtask

  logic [1:0] fwd_seq [4];
  logic [1:0] rev_seq [5];
  logic       bnc_a   [6];
  int         done_cnt;

  initial begin
    fwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    bnc_a   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; v0 = 1'b0; v4 = 1'b0; dir = 1'b0; steps = '0; dwell = '0; abort = 1'b0;
    step(); step();

    // Values held while reset is low
    check("rst_ab",    32'({a0, b0}), 32'd0);
    check("rst_pos",   32'(pos0),     32'd0);
    check("rst_ready", 32'(rdy0),     32'd1);
    check("rst_busy",  32'(busy0),    32'd0);
    check("rst_done",  32'(done0),    32'd0);
    check("rst_ab4",   32'({a4, b4}), 32'd0);

    // Forward 4 steps, dwell 3, offered on the first edge after reset release
    reset = 1'b1;
    dir = 1'b1; steps = 8'd4; dwell = 16'd3; v0 = 1'b1;
    step();
    v0 = 1'b0;
    // Change the command fields mid-run. The DUT should ignore them.
    dir = 1'b0; steps = 8'd7; dwell = 16'd9;
    check("fwd_pos_first", 32'(pos0), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      check("fwd_ab",   32'({a0, b0}), 32'(fwd_seq[(k - 1) / 3]));
      check("fwd_busy", 32'(busy0),    32'd1);
      check("fwd_done", 32'(done0),    32'd0);
      v0 = (k >= 2 && k <= 5);   // offered while busy: must be ignored
      step();
    end
    v0 = 1'b0;
    check("fwd_done_pulse", 32'(done0),    32'd1);
    check("fwd_ready",      32'(rdy0),     32'd1);
    check("fwd_pos",        32'(pos0),     32'd4);
    check("fwd_ab_final",   32'({a0, b0}), 32'd0);
    step();
    check("fwd_done_low",   32'(done0),    32'd0);

    // Reverse 5 steps, dwell 0 (treated as 1)
    dir = 1'b0; steps = 8'd5; dwell = 16'd0; v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("rev_ab",   32'({a0, b0}), 32'(rev_seq[k - 1]));
      check("rev_done", 32'(done0),    32'd0);
      step();
    end
    check("rev_done_pulse", 32'(done0), 32'd1);
    check("rev_pos",        32'(pos0),  32'hFFFF);

    // Chatter: forward 1 step, dwell 2, starting from phase 00
    dir = 1'b1; steps = 8'd1; dwell = 16'd2; v4 = 1'b1;
    step();
    v4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("bnc_a",    32'(a4),    32'(bnc_a[k - 1]));
      check("bnc_b",    32'(b4),    32'd0);
      check("bnc_done", 32'(done4), 32'd0);
      step();
    end
    check("bnc_done_pulse", 32'(done4), 32'd1);
    check("bnc_pos",        32'(pos4),  32'd1);
    check("bnc_ready",      32'(rdy4),  32'd1);

    // Abort during chatter. The phase is now 10, and a forward step moves b.
    dir = 1'b1; steps = 8'd3; dwell = 16'd2; v4 = 1'b1;
    step();
    v4 = 1'b0;
    check("abt_ab_c1", 32'({a4, b4}), 32'b11);
    step();
    check("abt_ab_c2", 32'({a4, b4}), 32'b10);   // b shows its old value
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_ready", 32'(rdy4),     32'd1);
    check("abt_ab",    32'({a4, b4}), 32'b11);
    check("abt_pos",   32'(pos4),     32'd2);
    check("abt_done",  32'(done4),    32'd0);
    dir = 1'b0; steps = 8'd1; dwell = 16'd1; v4 = 1'b1;
    step();
    v4 = 1'b0;
    check("abt_new_busy", 32'(busy4),    32'd1);
    check("abt_new_ab",   32'({a4, b4}), 32'b10);
    check("abt_new_pos",  32'(pos4),     32'd1);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done4) done_cnt++;
    end
    check("abt_new_early_done", 32'(done_cnt), 32'd0);
    step();
    check("abt_new_done", 32'(done4), 32'd1);

    // Wrap. dut0 is at -1 with phase 01; 32768 forward steps bring it to 32767.
    for (int c = 0; c < 128; c++) run_cmd0(1'b1, 8'd255, 16'd1, 300);
    run_cmd0(1'b1, 8'd128, 16'd1, 200);
    check("wrap_pre_pos", 32'(pos0),     32'h7FFF);
    check("wrap_pre_ab",  32'({a0, b0}), 32'b01);
    run_cmd0(1'b1, 8'd1, 16'd1, 10);
    check("wrap_pos", 32'(pos0),     32'h8000);
    check("wrap_ab",  32'({a0, b0}), 32'b00);

    // Zero steps: done in the next cycle, nothing else moves
    dir = 1'b1; steps = 8'd0; dwell = 16'd5; v0 = 1'b1;
    step();
    v0 = 1'b0;
    check("zero_done",  32'(done0),    32'd1);
    check("zero_ready", 32'(rdy0),     32'd1);
    check("zero_ab",    32'({a0, b0}), 32'b00);
    check("zero_pos",   32'(pos0),     32'h8000);
    step();
    check("zero_done_low", 32'(done0), 32'd0);

    // Asynchronous reset during step 2 of a 10-step command
    dir = 1'b1; steps = 8'd10; dwell = 16'd2; v0 = 1'b1;
    step();
    v0 = 1'b0;
    step(); step();
    check("ar_pre_ab", 32'({a0, b0}), 32'b11);
    #2 reset = 1'b0;
    #1;
    check("ar_ab",    32'({a0, b0}), 32'd0);
    check("ar_pos",   32'(pos0),     32'd0);
    check("ar_busy",  32'(busy0),    32'd0);
    check("ar_ready", 32'(rdy0),     32'd1);
    step();
    reset = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done0) done_cnt++;
    end
    check("ar_no_done",  32'(done_cnt),   32'd0);
    check("ar_idle_ab",  32'({a0, b0}),   32'd0);
    check("ar_idle_bsy", 32'(busy0),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
